// File: rtl/memory.sv
// Single-port synchronous word memory with a registered read port.
// Every access (write, read, idle or reset) takes effect on the rising edge of clk.
// dout always comes straight from a flop. Writes, idle cycles and reset cycles load it with zero.
module memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Storage array, indexed 0..DEPTH-1.
    // addr is exactly ADDR_WIDTH bits wide, so no index can fall out of range.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_en;
    logic                  rd_en;

    // Decode the access type and select the next read-data value.
    // addr and din are only looked at when cen is high,
    // so unknown values on those inputs during idle cycles are never used.
    always_comb begin
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        dout_d = '0;
        if (cen) begin
            wr_en = wen;
            rd_en = ~wen;
        end
        if (rd_en) begin
            dout_d = mem_q[addr];
        end
    end

    // Storage update. Reset clears every word and takes priority over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    // Read-data register. It returns zero on reset, write and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_memory.sv
// Directed, table-driven bench for the memory block.
// Each vector gives the inputs applied before an edge and the dout expected just after that edge.
module tb_memory;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        cen;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    memory #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .wen (wen),
        .addr(addr),
        .din (din),
        .dout(dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic r, input logic c, input logic w,
                                input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] e, input string nm);
        vec_t v;
        v.rst  = r;
        v.cen  = c;
        v.wen  = w;
        v.addr = a;
        v.din  = d;
        v.exp  = e;
        v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dout=%h expected %h", nm, act, exp);
        end
    endtask

    // Drive the inputs, clock one edge, then sample dout 1 ns after that edge.
    task automatic step(input logic r, input logic c, input logic w,
                        input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string nm);
        rst  = r;
        cen  = c;
        wen  = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        check(nm, dout, e);
    endtask

    initial begin
        rst  = 1'b1;
        cen  = 1'b0;
        wen  = 1'b0;
        addr = '0;
        din  = '0;

        // Reset for two cycles, then read every address and expect an empty memory.
        add(1, 0, 0, 5'h00, 32'h0, 32'h0, "reset0");
        add(1, 1, 1, 5'h00, 32'h0, 32'h0, "reset1");
        for (int i = 0; i < 32; i++) begin
            add(0, 1, 0, 5'(i), 32'h0, 32'h0, "read_after_reset");
        end
        // Write din=addr to 0x01..0x1F. dout must read zero during the writes.
        for (int i = 1; i < 32; i++) begin
            add(0, 1, 1, 5'(i), 32'(i), 32'h0, "write_dout_zero");
        end
        // Read the words back. Each one appears one cycle after its address.
        for (int i = 1; i < 32; i++) begin
            add(0, 1, 0, 5'(i), 32'h0, 32'(i), "read_back");
        end
        // A second write to the same address overwrites the first.
        add(0, 1, 1, 5'h1F, 32'hDEADBEEF, 32'h0, "overwrite_w1");
        add(0, 1, 1, 5'h1F, 32'h12345678, 32'h0, "overwrite_w2");
        add(0, 1, 0, 5'h1F, 32'h0, 32'h12345678, "overwrite_rd");
        add(0, 1, 0, 5'h00, 32'h0, 32'h0, "read_addr0");
        // Idle cycles with wen high must not write anything.
        for (int i = 0; i < 3; i++) begin
            add(0, 0, 1, 5'h05, 32'hFFFFFFFF, 32'h0, "idle_wen");
        end
        add(0, 1, 0, 5'h05, 32'h0, 32'h5, "idle_no_write");
        // A write followed immediately by a read of the same address.
        add(0, 1, 1, 5'h03, 32'hA5A50003, 32'h0, "wr_then_rd_w");
        add(0, 1, 0, 5'h03, 32'h0, 32'hA5A50003, "wr_then_rd_r");
        add(0, 1, 0, 5'h04, 32'h0, 32'h4, "neighbour_ok");

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].cen, vecs[k].wen, vecs[k].addr, vecs[k].din,
                 vecs[k].exp, vecs[k].name);
        end

        // Unknown addr/din while deselected must leave storage and dout alone.
        step(0, 0, 1, 5'bx, 32'bx, 32'h0, "x_idle0");
        step(0, 0, 1, 5'bx, 32'bx, 32'h0, "x_idle1");
        step(0, 1, 0, 5'h05, 32'h0, 32'h5, "x_idle_rd5");
        step(0, 1, 0, 5'h1F, 32'h0, 32'h12345678, "x_idle_rd1f");
        step(0, 1, 0, 5'h00, 32'h0, 32'h0, "x_idle_rd0");

        // Read data holds until the next edge, even after the inputs go idle.
        step(0, 1, 0, 5'h0A, 32'h0, 32'h0000000A, "hold_rd");
        cen  = 1'b0;
        addr = 5'h11;
        din  = 32'hFFFFFFFF;
        @(negedge clk);
        check("hold_mid_cycle", dout, 32'h0000000A);
        step(0, 0, 0, 5'h11, 32'h0, 32'h0, "hold_then_idle");

        // Reset in the middle of a read sequence, with a write requested on the reset edge.
        step(0, 1, 0, 5'h01, 32'h0, 32'h1, "seq_rd1");
        step(0, 1, 0, 5'h02, 32'h0, 32'h2, "seq_rd2");
        step(1, 1, 1, 5'h07, 32'hCAFEF00D, 32'h0, "seq_rst_edge");
        step(0, 1, 0, 5'h07, 32'h0, 32'h0, "rst_beats_write");
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 0, 5'(i), 32'h0, 32'h0, "read_after_mid_rst");
        end

        // The first access after reset release sees no extra latency.
        step(1, 0, 0, 5'h00, 32'h0, 32'h0, "rst_again");
        step(0, 1, 1, 5'h04, 32'h00000011, 32'h0, "first_wr");
        step(0, 1, 0, 5'h04, 32'h0, 32'h00000011, "first_rd");
        step(0, 1, 0, 5'h00, 32'h0, 32'h0, "first_rd0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
